// File: rtl/insmem_loader.sv
`default_nettype none
// ============================================================================
// Module      : insmem_loader
// Description : Write-side loader for the instruction memory. Accepts a
//               program image one word per VALID/READY transfer, writes it
//               at sequential addresses from 0, holds the processor while
//               loading and pulses DONE once the image is committed.
// Revision    : 1.0  initial release
// ============================================================================
module insmem_loader #(
   parameter int AddressWidth = 2,
   parameter int DataWidth    = 2
) (
   input  logic                    CLK,
   input  logic                    RST_N,
   input  logic                    START,
   input  logic [AddressWidth:0]   LEN,
   input  logic [DataWidth-1:0]    DATAIN,
   input  logic                    VALID,
   output logic                    READY,
   output logic                    WE,
   output logic [AddressWidth-1:0] WADD,
   output logic [DataWidth-1:0]    WDATA,
   output logic                    HOLD,
   output logic                    DONE,
   output logic [AddressWidth:0]   COUNT
);

   // Memory depth expressed in the LEN/COUNT width; used to clamp LEN so the
   // write address never wraps within one load.
   localparam logic [AddressWidth:0] c_DEPTH = {1'b1, {AddressWidth{1'b0}}};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t                  r_state, w_state_nxt;
   logic [AddressWidth:0]   r_len,   w_len_nxt;
   logic [AddressWidth:0]   r_count, w_count_nxt;
   logic [AddressWidth-1:0] r_wadd,  w_wadd_nxt;
   logic [DataWidth-1:0]    r_wdata, w_wdata_nxt;
   logic                    r_we,    w_we_nxt;
   logic                    r_hold,  w_hold_nxt;
   logic                    r_done,  w_done_nxt;
   logic [AddressWidth:0]   w_count_inc;

   assign w_count_inc = r_count + 1'b1;

   // State and registered outputs; reset leaves memory contents untouched.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state <= IDLE;
         r_len   <= '0;
         r_count <= '0;
         r_wadd  <= '0;
         r_wdata <= '0;
         r_we    <= 1'b0;
         r_hold  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_len   <= w_len_nxt;
         r_count <= w_count_nxt;
         r_wadd  <= w_wadd_nxt;
         r_wdata <= w_wdata_nxt;
         r_we    <= w_we_nxt;
         r_hold  <= w_hold_nxt;
         r_done  <= w_done_nxt;
      end
   end

   // Next-state and next-output decode; WE and DONE default low so they
   // only assert in the cycle following the event that requests them.
   always_comb begin
      w_state_nxt = r_state;
      w_len_nxt   = r_len;
      w_count_nxt = r_count;
      w_wadd_nxt  = r_wadd;
      w_wdata_nxt = r_wdata;
      w_we_nxt    = 1'b0;
      w_hold_nxt  = r_hold;
      w_done_nxt  = 1'b0;
      case (r_state)
         IDLE: begin
            if (START) begin
               w_count_nxt = '0;
               if (LEN != '0) begin
                  w_len_nxt   = (LEN > c_DEPTH) ? c_DEPTH : LEN;
                  w_hold_nxt  = 1'b1;
                  w_state_nxt = LOAD;
               end else begin
                  // Zero-length image: report completion without stalling.
                  w_done_nxt = 1'b1;
               end
            end
         end
         LOAD: begin
            if (VALID) begin
               w_we_nxt    = 1'b1;
               w_wadd_nxt  = r_count[AddressWidth-1:0];
               w_wdata_nxt = DATAIN;
               w_count_nxt = w_count_inc;
               if (w_count_inc == r_len) begin
                  w_state_nxt = DRAIN;
               end
            end
         end
         DRAIN: begin
            // Last word is committed at this edge; release the processor.
            w_done_nxt  = 1'b1;
            w_hold_nxt  = 1'b0;
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   assign READY = (r_state == LOAD);
   assign WE    = r_we;
   assign WADD  = r_wadd;
   assign WDATA = r_wdata;
   assign HOLD  = r_hold;
   assign DONE  = r_done;
   assign COUNT = r_count;

endmodule
`default_nettype wire

// File: tb/tb_insmem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_insmem_loader
// Description : Self-checking bench for insmem_loader (AW=2, DW=2). A table
//               of load descriptors drives the main cases; expected writes
//               go into a scoreboard queue and are popped as WE appears.
// Revision    : 1.0  initial release
// ============================================================================
module tb_insmem_loader;

   localparam int c_AW = 2;
   localparam int c_DW = 2;

   logic              CLK;
   logic              RST_N;
   logic              START;
   logic [c_AW:0]     LEN;
   logic [c_DW-1:0]   DATAIN;
   logic              VALID;
   logic              READY;
   logic              WE;
   logic [c_AW-1:0]   WADD;
   logic [c_DW-1:0]   WDATA;
   logic              HOLD;
   logic              DONE;
   logic [c_AW:0]     COUNT;

   int checks = 0;
   int errors = 0;
   int we_seen = 0;

   logic [c_AW+c_DW-1:0] sb[$];
   logic [c_DW-1:0]      mem     [4];
   logic [c_DW-1:0]      exp_mem [4];

   typedef struct {
      logic [2:0]  len;
      logic [7:0]  pat;       // VALID per load cycle, bit 0 first
      logic [15:0] data;      // accepted word i = data[2i +: 2]
      int          exp_n;     // expected number of writes / final COUNT
      bit          start_mid; // pulse START during LOAD
   } load_vec_t;

   load_vec_t vecs[5];

   insmem_loader #(
      .AddressWidth(c_AW),
      .DataWidth   (c_DW)
   ) u_dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .START (START),
      .LEN   (LEN),
      .DATAIN(DATAIN),
      .VALID (VALID),
      .READY (READY),
      .WE    (WE),
      .WADD  (WADD),
      .WDATA (WDATA),
      .HOLD  (HOLD),
      .DONE  (DONE),
      .COUNT (COUNT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Instruction memory array driven by the loader's write port.
   always @(posedge CLK) begin
      if (WE) mem[WADD] <= WDATA;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard: every WE cycle must match the oldest outstanding write.
   always @(negedge CLK) begin
      if (RST_N && WE) begin
         we_seen++;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected_we: WADD=%0h WDATA=%0h with nothing expected", WADD, WDATA);
         end else begin
            chk("sb_write", {28'd0, WADD, WDATA}, {28'd0, sb.pop_front()});
         end
      end
   end

   task automatic run_load(input load_vec_t v);
      int acc;
      int cyc;
      bit drv;
      logic [c_DW-1:0] d;
      logic [c_AW-1:0] a;
      we_seen = 0;
      @(negedge CLK);
      START = 1'b1;
      LEN   = v.len;
      VALID = 1'b0;
      @(posedge CLK);
      @(negedge CLK);
      START = 1'b0;
      if (v.len == 3'd0) begin
         chk("zl_done",  DONE,  1);
         chk("zl_hold",  HOLD,  0);
         chk("zl_ready", READY, 0);
         chk("zl_count", COUNT, 0);
         @(negedge CLK);
         chk("zl_done_fall", DONE, 0);
         chk("zl_hold2",     HOLD, 0);
         chk("zl_no_we",     we_seen, 0);
         return;
      end
      chk("ld_hold_rise", HOLD,  1);
      chk("ld_count0",    COUNT, 0);
      acc = 0;
      cyc = 0;
      while (acc < v.exp_n && cyc < 40) begin
         chk("ld_ready", READY, 1);
         chk("ld_hold",  HOLD,  1);
         chk("ld_done0", DONE,  0);
         drv    = v.pat[cyc % 8];
         START  = v.start_mid && (cyc == 1);
         LEN    = 3'd1;
         VALID  = drv;
         d      = v.data[2*acc +: 2];
         DATAIN = d;
         if (drv) begin
            a = acc[c_AW-1:0];
            sb.push_back({a, d});
            exp_mem[acc] = d;
            acc++;
         end
         cyc++;
         @(posedge CLK);
         @(negedge CLK);
      end
      VALID = 1'b0;
      START = 1'b0;
      if (acc < v.exp_n) begin
         checks++;
         errors++;
         $display("FAIL ld_timeout: accepted %0d of %0d words", acc, v.exp_n);
      end
      // Last word was accepted at the edge just passed: WE high, DONE not yet.
      chk("dr_ready", READY, 0);
      chk("dr_done",  DONE,  0);
      chk("dr_hold",  HOLD,  1);
      @(negedge CLK);
      chk("end_done",  DONE,  1);
      chk("end_hold",  HOLD,  0);
      chk("end_we",    WE,    0);
      chk("end_count", COUNT, v.exp_n);
      @(negedge CLK);
      chk("end_done_fall", DONE,  0);
      chk("end_count_hold", COUNT, v.exp_n);
      chk("end_nwrites",   we_seen, v.exp_n);
      for (int i = 0; i < v.exp_n; i++) begin
         chk("mem_readback", mem[i], exp_mem[i]);
      end
   endtask

   initial begin
      // Full load 01,10,11,00; host stalls; clamp with ignored START;
      // zero length; single word after two idle host cycles.
      vecs[0] = '{len: 3'd4, pat: 8'hFF, data: 16'h0039, exp_n: 4, start_mid: 1'b0};
      vecs[1] = '{len: 3'd3, pat: 8'h29, data: 16'h002D, exp_n: 3, start_mid: 1'b0};
      vecs[2] = '{len: 3'd7, pat: 8'hFF, data: 16'h00E4, exp_n: 4, start_mid: 1'b1};
      vecs[3] = '{len: 3'd0, pat: 8'hFF, data: 16'h0000, exp_n: 0, start_mid: 1'b0};
      vecs[4] = '{len: 3'd1, pat: 8'h04, data: 16'h0002, exp_n: 1, start_mid: 1'b0};

      RST_N  = 1'b0;
      START  = 1'b0;
      LEN    = '0;
      DATAIN = '0;
      VALID  = 1'b0;
      #12;
      chk("rst_ready", READY, 0);
      chk("rst_hold",  HOLD,  0);
      chk("rst_we",    WE,    0);
      chk("rst_done",  DONE,  0);
      chk("rst_wadd",  WADD,  0);
      chk("rst_count", COUNT, 0);
      @(negedge CLK);
      RST_N = 1'b1;

      for (int i = 0; i < 5; i++) begin
         run_load(vecs[i]);
      end

      // VALID while idle must not write or move COUNT.
      we_seen = 0;
      @(negedge CLK);
      VALID  = 1'b1;
      DATAIN = 2'b11;
      repeat (3) @(negedge CLK);
      chk("idle_valid_count", COUNT, 1);
      chk("idle_valid_we",    we_seen, 0);
      chk("idle_valid_ready", READY, 0);
      VALID = 1'b0;

      // Asynchronous reset in the middle of a load.
      @(negedge CLK);
      START = 1'b1;
      LEN   = 3'd4;
      @(posedge CLK);
      @(negedge CLK);
      START  = 1'b0;
      VALID  = 1'b1;
      DATAIN = 2'b01;
      sb.push_back({2'd0, 2'b01});
      @(posedge CLK);
      @(negedge CLK);
      DATAIN = 2'b10;
      sb.push_back({2'd1, 2'b10});
      @(posedge CLK);
      @(negedge CLK);
      VALID = 1'b0;
      #1 RST_N = 1'b0;
      #1;
      chk("arst_ready", READY, 0);
      chk("arst_hold",  HOLD,  0);
      chk("arst_we",    WE,    0);
      chk("arst_done",  DONE,  0);
      chk("arst_wadd",  WADD,  0);
      chk("arst_wdata", WDATA, 0);
      chk("arst_count", COUNT, 0);
      sb.delete();
      #1 RST_N = 1'b1;
      run_load('{len: 3'd1, pat: 8'hFF, data: 16'h0003, exp_n: 1, start_mid: 1'b0});

      repeat (2) @(negedge CLK);
      chk("sb_drained", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Global watchdog so the run always terminates.
   initial begin
      #20000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
